// File: rtl/elevator_pkg.sv
// Shared types and default geometry for the elevator scheduler slice.
package elevator_pkg;

    localparam int DEF_NUM_FLOORS = 8;
    localparam int DEF_FLOOR_W    = 3;

    typedef logic [DEF_FLOOR_W-1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2,
        DWELL = 2'd3
    } state_t;

endpackage

// File: rtl/elevator_floor_search.sv
// Combinational search of the pending-call vector relative to the car position:
// nearest call above, nearest call below, and a call at the current floor.
module elevator_floor_search
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = DEF_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic                  above_vld,
    output logic [FLOOR_W-1:0]    above,
    output logic                  below_vld,
    output logic [FLOOR_W-1:0]    below,
    output logic                  here
);

    always_comb begin
        above_vld = 1'b0;
        above     = '0;
        below_vld = 1'b0;
        below     = '0;
        here      = 1'b0;
        // Scan downward so the last hit above the car is the lowest one.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) > cur_floor)) begin
                above_vld = 1'b1;
                above     = FLOOR_W'(i);
            end
        end
        // Scan upward so the last hit below the car is the highest one.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) < cur_floor)) begin
                below_vld = 1'b1;
                below     = FLOOR_W'(i);
            end
            if (pending[i] && (FLOOR_W'(i) == cur_floor)) begin
                here = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-ordered scheduler for a single car: latches floor calls, picks the next
// target in the sweep direction, dwells at each served floor, then reverses.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
    parameter int FLOOR_W      = DEF_FLOOR_W,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  door,
    output logic [FLOOR_W-1:0]    req_floor,
    output logic                  req_valid,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [1:0]            state
);

    localparam int CNT_W = (DWELL_CYCLES < 2) ? 1 : $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES);

    logic [NUM_FLOORS-1:0] pending_q, pending_d, clr;
    state_t                state_q;
    logic [FLOOR_W-1:0]    req_floor_q;
    logic                  req_valid_q;
    logic                  dir_up_q;
    logic [CNT_W-1:0]      dwell_cnt_q;

    logic                  above_vld, below_vld, here, cur_ok;
    logic [FLOOR_W-1:0]    above, below;

    elevator_floor_search #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_search (
        .pending   (pending_q),
        .cur_floor (cur_floor),
        .above_vld (above_vld),
        .above     (above),
        .below_vld (below_vld),
        .below     (below),
        .here      (here)
    );

    // An out-of-range position freezes the FSM; calls keep latching.
    assign cur_ok = ({1'b0, cur_floor} < (FLOOR_W + 1)'(NUM_FLOORS));

    always_comb begin
        clr = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            clr[f] = door && (cur_floor == FLOOR_W'(f));
        end
        pending_d = (pending_q | call_req) & ~clr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_floor_q <= '0;
            req_valid_q <= 1'b0;
            dir_up_q    <= 1'b1;
            dwell_cnt_q <= '0;
        end else if (cur_ok) begin
            case (state_q)
                IDLE: begin
                    req_valid_q <= 1'b0;
                    if (here) begin
                        req_floor_q <= cur_floor;
                        if (door) begin
                            state_q     <= DWELL;
                            dwell_cnt_q <= DWELL_LOAD;
                        end else begin
                            req_valid_q <= 1'b1;
                        end
                    end else if (above_vld) begin
                        state_q     <= UP;
                        dir_up_q    <= 1'b1;
                        req_floor_q <= above;
                        req_valid_q <= 1'b1;
                    end else if (below_vld) begin
                        state_q     <= DOWN;
                        dir_up_q    <= 1'b0;
                        req_floor_q <= below;
                        req_valid_q <= 1'b1;
                    end
                end
                UP: begin
                    if (door && (cur_floor == req_floor_q)) begin
                        state_q     <= DWELL;
                        req_valid_q <= 1'b0;
                        dwell_cnt_q <= DWELL_LOAD;
                    end else if (above_vld && (above < req_floor_q)) begin
                        req_floor_q <= above;
                    end
                end
                DOWN: begin
                    if (door && (cur_floor == req_floor_q)) begin
                        state_q     <= DWELL;
                        req_valid_q <= 1'b0;
                        dwell_cnt_q <= DWELL_LOAD;
                    end else if (below_vld && (below > req_floor_q)) begin
                        req_floor_q <= below;
                    end
                end
                DWELL: begin
                    if (dwell_cnt_q != '0) begin
                        dwell_cnt_q <= dwell_cnt_q - CNT_W'(1);
                    end else if (!door) begin
                        // Continue the sweep first; reverse only when nothing lies ahead.
                        if ((dir_up_q && above_vld) || (!below_vld && above_vld)) begin
                            state_q     <= UP;
                            dir_up_q    <= 1'b1;
                            req_floor_q <= above;
                            req_valid_q <= 1'b1;
                        end else if (below_vld) begin
                            state_q     <= DOWN;
                            dir_up_q    <= 1'b0;
                            req_floor_q <= below;
                            req_valid_q <= 1'b1;
                        end else if (here) begin
                            dwell_cnt_q <= DWELL_LOAD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pending   = pending_q;
    assign state     = state_q;
    assign req_floor = req_floor_q;
    assign req_valid = req_valid_q;
    assign dir_up    = dir_up_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: a vector table for a full up/down sweep
// plus hand-written sequences for retarget, reversal, here-calls and async reset.
module tb_elevator_scheduler;
    import elevator_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] call_req = '0;
    floor_t     cur_floor = '0;
    logic       door = 1'b0;
    floor_t     req_floor;
    logic       req_valid;
    logic       dir_up;
    logic [7:0] pending;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    elevator_scheduler #(
        .NUM_FLOORS   (8),
        .FLOOR_W      (3),
        .DWELL_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .call_req  (call_req),
        .cur_floor (cur_floor),
        .door      (door),
        .req_floor (req_floor),
        .req_valid (req_valid),
        .dir_up    (dir_up),
        .pending   (pending),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] call;
        floor_t     cur;
        logic       door;
        logic [7:0] pend;
        logic [1:0] st;
        floor_t     rf;
        logic       rv;
        logic       up;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        call_req  = '0;
        cur_floor = '0;
        door      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_out(input string tag, input int st, input int rf, input int rv, input int up);
        chk({tag, "_state"}, int'(state), st);
        chk({tag, "_req_floor"}, int'(req_floor), rf);
        chk({tag, "_req_valid"}, int'(req_valid), rv);
        chk({tag, "_dir_up"}, int'(dir_up), up);
    endtask

    // Steps until the FSM leaves DWELL; n is the number of steps taken.
    task automatic wait_exit(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (state != 2'd3) break;
            step();
            n++;
        end
    endtask

    initial begin
        int n;

        // Full sweep: up to 3 with a served floor-1 side call, then down to 0, then idle.
        vt[0]  = '{8'h08, 3'd0, 1'b0, 8'h08, 2'd0, 3'd0, 1'b0, 1'b1};
        vt[1]  = '{8'h00, 3'd0, 1'b0, 8'h08, 2'd1, 3'd3, 1'b1, 1'b1};
        vt[2]  = '{8'h00, 3'd1, 1'b0, 8'h08, 2'd1, 3'd3, 1'b1, 1'b1};
        vt[3]  = '{8'h02, 3'd1, 1'b0, 8'h0A, 2'd1, 3'd3, 1'b1, 1'b1};
        vt[4]  = '{8'h00, 3'd1, 1'b1, 8'h08, 2'd1, 3'd3, 1'b1, 1'b1};
        vt[5]  = '{8'h00, 3'd3, 1'b1, 8'h00, 2'd3, 3'd3, 1'b0, 1'b1};
        vt[6]  = '{8'h01, 3'd3, 1'b0, 8'h01, 2'd3, 3'd3, 1'b0, 1'b1};
        vt[7]  = '{8'h00, 3'd3, 1'b0, 8'h01, 2'd3, 3'd3, 1'b0, 1'b1};
        vt[8]  = '{8'h00, 3'd3, 1'b0, 8'h01, 2'd3, 3'd3, 1'b0, 1'b1};
        vt[9]  = '{8'h00, 3'd3, 1'b0, 8'h01, 2'd3, 3'd3, 1'b0, 1'b1};
        vt[10] = '{8'h00, 3'd3, 1'b0, 8'h01, 2'd2, 3'd0, 1'b1, 1'b0};
        vt[11] = '{8'h00, 3'd0, 1'b1, 8'h00, 2'd3, 3'd0, 1'b0, 1'b0};
        vt[12] = '{8'h00, 3'd0, 1'b0, 8'h00, 2'd3, 3'd0, 1'b0, 1'b0};
        vt[13] = '{8'h00, 3'd0, 1'b0, 8'h00, 2'd3, 3'd0, 1'b0, 1'b0};
        vt[14] = '{8'h00, 3'd0, 1'b0, 8'h00, 2'd3, 3'd0, 1'b0, 1'b0};
        vt[15] = '{8'h00, 3'd0, 1'b0, 8'h00, 2'd3, 3'd0, 1'b0, 1'b0};
        vt[16] = '{8'h00, 3'd0, 1'b0, 8'h00, 2'd0, 3'd0, 1'b0, 1'b0};

        do_reset();
        chk("rst_pending", int'(pending), 0);
        chk_out("rst", 0, 0, 0, 1);

        for (int i = 0; i < 17; i++) begin
            call_req  = vt[i].call;
            cur_floor = vt[i].cur;
            door      = vt[i].door;
            step();
            chk($sformatf("vec%0d_pending", i), int'(pending), int'(vt[i].pend));
            chk_out($sformatf("vec%0d", i), int'(vt[i].st), int'(vt[i].rf), int'(vt[i].rv), int'(vt[i].up));
        end
        call_req = '0;
        door     = 1'b0;

        // Retarget to a closer call while sweeping up, then dwell and resume.
        do_reset();
        cur_floor = 3'd2;
        call_req  = 8'h40;
        step();
        call_req = '0;
        step();
        chk_out("rt_start", 1, 6, 1, 1);
        call_req = 8'h10;
        step();
        call_req = '0;
        chk("rt_mid_req_floor", int'(req_floor), 6);
        step();
        chk("rt_req_floor", int'(req_floor), 4);
        cur_floor = 3'd4;
        door      = 1'b1;
        step();
        door = 1'b0;
        chk("rt_pending", int'(pending), 8'h40);
        chk("rt_dwell_state", int'(state), 3);
        wait_exit(n);
        chk("rt_dwell_len_ge4", (n >= 4) ? 1 : 0, 1);
        chk_out("rt_resume", 1, 6, 1, 1);

        // Reversal: serve 7 at the top, then head down to 2, then go idle.
        do_reset();
        cur_floor = 3'd5;
        call_req  = 8'h84;
        step();
        call_req = '0;
        step();
        chk_out("rev_up", 1, 7, 1, 1);
        cur_floor = 3'd7;
        door      = 1'b1;
        step();
        door = 1'b0;
        chk("rev_top_pending", int'(pending), 8'h04);
        chk("rev_top_state", int'(state), 3);
        wait_exit(n);
        chk_out("rev_down", 2, 2, 1, 0);
        cur_floor = 3'd2;
        door      = 1'b1;
        step();
        door = 1'b0;
        chk("rev_bot_pending", int'(pending), 0);
        wait_exit(n);
        chk_out("rev_idle", 0, 2, 0, 0);

        // Call at the current floor while idle.
        do_reset();
        cur_floor = 3'd3;
        call_req  = 8'h08;
        step();
        call_req = '0;
        chk("here_pending", int'(pending), 8'h08);
        chk("here_state_n1", int'(state), 0);
        step();
        chk_out("here_req", 0, 3, 1, 1);
        door = 1'b1;
        step();
        chk("here_clr_pending", int'(pending), 0);
        chk("here_dwell", int'(state), 3);

        // Set and clear in the same cycle at the open-door floor.
        cur_floor = 3'd2;
        call_req  = 8'h04;
        step();
        call_req = '0;
        chk("setclr_pending", int'(pending), 0);
        door = 1'b0;

        // Asynchronous reset in the middle of an up sweep.
        do_reset();
        call_req = 8'h20;
        step();
        call_req = '0;
        step();
        chk_out("ar_pre", 1, 5, 1, 1);
        call_req = 8'h02;
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_pending", int'(pending), 0);
        chk_out("ar", 0, 0, 0, 1);
        call_req = '0;
        step();
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Collects floor calls from per-floor buttons into a pending-request register.
- Sequences the single-car elevator FSM with SCAN ordering: keep moving in the current direction while calls remain ahead, then reverse.
- Drives the elevator's req_floor input.
- Observes the elevator's current-floor output y (as cur_floor) and its door output (as door).

Parameters:
- NUM_FLOORS, 8, number of served floors (0 = G). Must be ≤ 2**FLOOR_W.
- FLOOR_W, 3, floor index width. Matches elevator req_floor/y.
- DWELL_CYCLES, 4, minimum cycles held in DWELL after door-open is seen at a target.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- call_req  in  NUM_FLOORS  floor call buttons. Level or pulse; bit f is ORed into pending every cycle it is high.
- cur_floor  in  FLOOR_W  current car position, from the elevator y output.
- door  in  1  elevator door status; 1 = open.
- req_floor  out  FLOOR_W  target floor presented to the elevator.
- req_valid  out  1  req_floor is a live target.
- dir_up  out  1  sweep direction; 1 = up.
- pending  out  NUM_FLOORS  outstanding calls.
- state  out  2  FSM state: IDLE=0, UP=1, DOWN=2, DWELL=3.

Behaviour:
- Clocking: all outputs are registered; no combinational input-to-output path.
- Reset (async assert, sync release):
  - pending=0, state=IDLE, req_floor=0, req_valid=0, dir_up=1, dwell counter=0.
  - Reset mid-operation discards all calls.
- Pending update: pending[f] <= (pending[f] | call_req[f]) & ~clr[f], where clr[f] = door & (cur_floor==f).
  - Clear wins over a simultaneous set: a call at the open-door floor is already served.
- Search (combinational, on registered pending):
  - above = lowest pending index > cur_floor.
  - below = highest pending index < cur_floor.
  - here = pending[cur_floor].
- IDLE:
  - req_valid=0.
  - If here: req_floor=cur_floor, req_valid=1, stay in IDLE until door=1, then go to DWELL.
  - Else if above exists: go to UP, dir_up=1, req_floor=above.
  - Else if below exists: go to DOWN, dir_up=0, req_floor=below.
- UP:
  - req_valid=1.
  - Retarget: if a new pending floor f satisfies cur_floor < f < req_floor, then req_floor <= f. No other change of req_floor is allowed while req_valid=1.
  - When door=1 and cur_floor==req_floor: go to DWELL, req_valid=0, load dwell counter.
- DOWN: mirror of UP (retarget when req_floor < f < cur_floor).
- DWELL:
  - req_floor holds its value; counter decrements to 0.
  - Exit when counter==0 and door==0.
  - Next state:
    - If dir_up and above exists: UP.
    - Else if !dir_up and below exists: DOWN.
    - Else if the opposite direction has calls: reverse, flip dir_up, and target the nearest call in the new direction.
    - Else if here: stay in DWELL, counter reloads.
    - Else: IDLE.
- Latency:
  - call_req high at edge n sets pending at n+1.
  - In IDLE, state, req_floor and req_valid update at n+2.
- Boundaries:
  - Floor 0 has no below; floor NUM_FLOORS-1 has no above.
  - cur_floor ≥ NUM_FLOORS is treated as no-search: no transitions, pending still latches.
  - call_req bits at or above NUM_FLOORS are ignored.
  - door=1 at a non-target floor has no FSM effect, but still clears pending at that floor.

Decomposition:
- Package elevator_pkg holds:
  - state_t enum: IDLE, UP, DOWN, DWELL.
  - FLOOR_W and NUM_FLOORS defaults.
  - floor_t typedef (logic [FLOOR_W-1:0]).
- Sub-module elevator_floor_search (combinational):
  - Inputs: pending, cur_floor.
  - Outputs: above_vld, above, below_vld, below, here.
  - Instantiated once.
- The top module holds the pending register, FSM and dwell counter.

Test Plan:
- Reset release, cur_floor=0, door=0, one-cycle pulse of call_req[3] → pending=8'h08 at n+1; state=UP, dir_up=1, req_floor=3, req_valid=1 at n+2.
- Retarget: moving UP to 6, cur_floor=2, pulse call_req[4] → req_floor becomes 4 two cycles later. After door=1 at floor 4: pending[4]=0 and DWELL lasts ≥4 cycles; after door=0, UP with req_floor=6.
- Reversal: at floor 5 UP with pending{7,2} → serve 7, DWELL, then state=DOWN, dir_up=0, req_floor=2. pending becomes 8'h00 after floor 2 is served; state returns to IDLE, req_valid=0.
- Call at current floor in IDLE: cur_floor=3, door=0, call_req[3] → req_floor=3, req_valid=1, state stays IDLE. door=1 → pending[3]=0 and state=DWELL.
- Simultaneous set/clear: door=1, cur_floor=2, call_req[2]=1 in the same cycle → pending[2] stays 0.
- Async reset: assert reset_n=0 mid-UP between clock edges → state=IDLE, req_valid=0, req_floor=0, pending=0, dir_up=1 immediately, without waiting for a clock edge.
